// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO controller.
//   GPIO_AW          register address width
//   GPIO_DATA_OUT .. GPIO_OUT_CLR  register indices
//   deb_cnt_width()  width of the per-pin debounce counter
package gpio_pkg;

    localparam int GPIO_AW = 3;

    localparam logic [GPIO_AW-1:0] GPIO_DATA_OUT    = 3'd0;
    localparam logic [GPIO_AW-1:0] GPIO_DIR         = 3'd1;
    localparam logic [GPIO_AW-1:0] GPIO_DATA_IN     = 3'd2;
    localparam logic [GPIO_AW-1:0] GPIO_IRQ_EN_RISE = 3'd3;
    localparam logic [GPIO_AW-1:0] GPIO_IRQ_EN_FALL = 3'd4;
    localparam logic [GPIO_AW-1:0] GPIO_IRQ_STATUS  = 3'd5;
    localparam logic [GPIO_AW-1:0] GPIO_OUT_SET     = 3'd6;
    localparam logic [GPIO_AW-1:0] GPIO_OUT_CLR     = 3'd7;

    // Counter must hold DEB_CYCLES; never narrower than one bit.
    function automatic int deb_cnt_width(input int deb);
        return (deb < 1) ? 1 : $clog2(deb + 1);
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: one pin of the input path.
//   Two-flop synchroniser followed by a debounce filter; the filtered value only
//   follows the synchronised pad after it has differed for DEB_CYCLES cycles.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   pad_in         raw asynchronous pad input
//   filtered       debounced pin value
//   rise, fall     one-cycle pulses in the cycle after filtered changes
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad_in,
    output logic filtered,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic filt_dly_q, filt_dly_d;
    logic filt_w;

    assign sync1_d    = pad_in;
    assign sync2_d    = sync1_q;
    assign filt_dly_d = filt_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_dly_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_dly_q <= filt_dly_d;
        end
    end

    if (DEB_CYCLES == 0) begin : g_bypass
        assign filt_w = sync2_q;
    end else begin : g_deb
        localparam int CW = deb_cnt_width(DEB_CYCLES);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          filt_q, filt_d;

        // The counter tracks consecutive cycles of disagreement; it is cleared
        // before it can exceed DEB_CYCLES-1, so it never wraps.
        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            if (sync2_q == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign filt_w = filt_q;
    end

    assign filtered = filt_w;
    assign rise     = filt_w & ~filt_dly_q;
    assign fall     = ~filt_w & filt_dly_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: N-pin GPIO controller with register interface.
//   Register file (DATA_OUT, DIR, enables, W1C status), registered read port,
//   per-pin filtered inputs with edge interrupts and a registered irq.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en, rd_en, addr    register strobes and index
//   wdata / rdata, rvalid write data / registered read data and its valid
//   pad_in                asynchronous pad inputs
//   pad_out, pad_oe       pad drive data and enable (DATA_OUT, DIR)
//   irq                   registered OR of IRQ_STATUS
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int N          = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [GPIO_AW-1:0] addr,
    input  logic [N-1:0]       wdata,
    output logic [N-1:0]       rdata,
    output logic               rvalid,
    input  logic [N-1:0]       pad_in,
    output logic [N-1:0]       pad_out,
    output logic [N-1:0]       pad_oe,
    output logic               irq
);

    logic [N-1:0] filtered, rise, fall;

    for (genvar gi = 0; gi < N; gi++) begin : g_pin
        gpio_in_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
            .clk      (clk),
            .reset_n  (reset_n),
            .pad_in   (pad_in[gi]),
            .filtered (filtered[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi])
        );
    end

    logic [N-1:0] data_out_q, data_out_d;
    logic [N-1:0] dir_q, dir_d;
    logic [N-1:0] en_rise_q, en_rise_d;
    logic [N-1:0] en_fall_q, en_fall_d;
    logic [N-1:0] status_q, status_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         rvalid_q, rvalid_d;
    logic         irq_q, irq_d;
    logic [N-1:0] rd_mux, w1c_mask, events;

    always_comb begin
        rd_mux = '0;
        case (addr)
            GPIO_DATA_OUT:    rd_mux = data_out_q;
            GPIO_DIR:         rd_mux = dir_q;
            GPIO_DATA_IN:     rd_mux = filtered;
            GPIO_IRQ_EN_RISE: rd_mux = en_rise_q;
            GPIO_IRQ_EN_FALL: rd_mux = en_fall_q;
            GPIO_IRQ_STATUS:  rd_mux = status_q;
            default:          rd_mux = '0;
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        en_rise_d  = en_rise_q;
        en_fall_d  = en_fall_q;
        w1c_mask   = '0;
        if (wr_en) begin
            case (addr)
                GPIO_DATA_OUT:    data_out_d = wdata;
                GPIO_DIR:         dir_d      = wdata;
                GPIO_IRQ_EN_RISE: en_rise_d  = wdata;
                GPIO_IRQ_EN_FALL: en_fall_d  = wdata;
                GPIO_IRQ_STATUS:  w1c_mask   = wdata;
                GPIO_OUT_SET:     data_out_d = data_out_q | wdata;
                GPIO_OUT_CLR:     data_out_d = data_out_q & ~wdata;
                default:          ;
            endcase
        end
        // Events are OR-ed after the clear so a simultaneous new edge wins.
        events   = (rise & en_rise_q) | (fall & en_fall_q);
        status_d = (status_q & ~w1c_mask) | events;
        rdata_d  = rd_en ? rd_mux : rdata_q;
        rvalid_d = rd_en;
        irq_d    = |status_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            en_rise_q  <= '0;
            en_fall_q  <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            en_rise_q  <= en_rise_d;
            en_fall_q  <= en_fall_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign pad_out = data_out_q;
    assign pad_oe  = dir_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign irq     = irq_q;

endmodule
